// File: rtl/binary_down_counter_if.sv
// Load port for binary_down_counter: a producer offers an interval over
// valid/ready, and the counter accepts it when both are high on an edge.
interface binary_down_counter_if #(
    parameter int N = 8
);
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_value;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );
endinterface

// File: rtl/binary_down_counter.sv
// Loadable N-bit down counter. It counts a programmed interval down to zero
// and pulses tc for one cycle at expiry.
//
// Optional feature: define LIBSV_COUNTERS_BINARY_DOWN_COUNTER_AUTORELOAD_EN
// to make the counter periodic. At expiry it reloads from rl and stays in
// RUN. Loads are then accepted in every state, and a load during RUN only
// updates rl.
//
// state | meaning
// IDLE  | waiting for a load, q holds its last value
// RUN   | counting down on enabled cycles
module binary_down_counter #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   aresetn,
    binary_down_counter_if.slave   load,
    input  logic                   en,
    input  logic                   stop,
    output logic [N-1:0]           q,
    output logic                   busy,
    output logic                   tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = N'(1);

    state_t       state;
    logic [N-1:0] rl;
    logic         load_fire;

`ifdef LIBSV_COUNTERS_BINARY_DOWN_COUNTER_AUTORELOAD_EN
    assign load.load_ready = 1'b1;
`else
    assign load.load_ready = (state == IDLE);
`endif

    assign load_fire = load.load_valid && load.load_ready;
    assign busy      = (state == RUN);

    // Counter state machine: load, count down, expire, stop. tc is 0 unless a cycle sets it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            q     <= ZERO;
            rl    <= ZERO;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_fire) begin
                        q  <= load.load_value;
                        rl <= load.load_value;
                        if (load.load_value != ZERO) begin
                            state <= RUN;
                        end else begin
                            // A zero interval expires immediately without entering RUN.
                            tc <= 1'b1;
                        end
                    end
                end
                RUN: begin
`ifdef LIBSV_COUNTERS_BINARY_DOWN_COUNTER_AUTORELOAD_EN
                    // New interval is latched now and takes effect at the next reload.
                    if (load_fire) begin
                        rl <= load.load_value;
                    end
`endif
                    if (stop) begin
                        state <= IDLE;
                    end else if (en) begin
                        if (q == ONE) begin
                            tc <= 1'b1;
`ifdef LIBSV_COUNTERS_BINARY_DOWN_COUNTER_AUTORELOAD_EN
                            q <= rl;
                            if (rl == ZERO) begin
                                state <= IDLE;
                            end
`else
                            q     <= ZERO;
                            state <= IDLE;
`endif
                        end else begin
                            q <= q - ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_down_counter.sv
// Bench for binary_down_counter. It runs table-driven per-cycle vectors
// through an expected-result queue, then hand-written sequences for full
// range and async reset.
module tb_binary_down_counter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         en = 1'b0;
    logic         stop = 1'b0;
    logic [N-1:0] q;
    logic         busy;
    logic         tc;

    binary_down_counter_if #(.N(N)) lif ();

    binary_down_counter #(.N(N)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .load    (lif),
        .en      (en),
        .stop    (stop),
        .q       (q),
        .busy    (busy),
        .tc      (tc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         lv;
        logic [N-1:0] val;
        logic         en;
        logic         stop;
        logic [N-1:0] eq;
        logic         eb;
        logic         etc;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] q;
        logic         b;
        logic         tc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   applied = 0;
    int   miscompares = 0;

    function automatic logic exp_ready(logic b);
`ifdef LIBSV_COUNTERS_BINARY_DOWN_COUNTER_AUTORELOAD_EN
        return 1'b1;
`else
        return !b;
`endif
    endfunction

    task automatic check(input string name, input logic [N-1:0] eq,
                         input logic eb, input logic etc);
        logic er;
        er = exp_ready(eb);
        applied++;
        if (q !== eq || busy !== eb || tc !== etc || lif.load_ready !== er) begin
            miscompares++;
            $display("FAIL %s: got q=%0d busy=%0b tc=%0b ready=%0b, want q=%0d busy=%0b tc=%0b ready=%0b",
                     name, q, busy, tc, lif.load_ready, eq, eb, etc, er);
        end
    endtask

    task automatic add(input logic lv, input int val, input logic e, input logic s,
                       input int eq, input logic eb, input logic etc);
        vec_t v;
        v.lv = lv; v.val = val[N-1:0]; v.en = e; v.stop = s;
        v.eq = eq[N-1:0]; v.eb = eb; v.etc = etc;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        lif.load_valid = v.lv;
        lif.load_value = v.val;
        en             = v.en;
        stop           = v.stop;
        sb.push_back({v.eq, v.eb, v.etc});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            applied++;
            miscompares++;
            $display("FAIL %s: scoreboard empty, got q=%0d, want an entry", name, q);
        end else begin
            e = sb.pop_front();
            check(name, e.q, e.b, e.tc);
        end
    endtask

    initial begin
        int   n;
        vec_t v;

        lif.load_valid = 1'b0;
        lif.load_value = '0;

`ifndef LIBSV_COUNTERS_BINARY_DOWN_COUNTER_AUTORELOAD_EN
        // load 5, en held: 5,4,3,2,1,0 with tc only at 0
        add(1, 5, 1, 0, 5, 1, 0);
        add(0, 0, 1, 0, 4, 1, 0);
        add(0, 0, 1, 0, 3, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0);
        // load 3, en low for 4 cycles at q=2
        add(1, 3, 1, 0, 3, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        // load held through RUN is refused, then accepted in the tc cycle
        add(1, 1, 1, 0, 1, 1, 0);
        add(1, 2, 1, 0, 0, 0, 1);
        add(1, 2, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
`else
        // load 4: tc every 4 cycles; load 2 mid-period; load 0 ends it
        add(1, 4, 1, 0, 4, 1, 0);
        add(0, 0, 1, 0, 3, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 4, 1, 1);
        add(0, 0, 1, 0, 3, 1, 0);
        add(1, 2, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 2, 1, 1);
        add(1, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0);
`endif
        // load 0: single tc, busy stays 0
        add(1, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0);
        // load attempt during RUN, then stop at q=4, then stop in IDLE
        add(1, 6, 1, 0, 6, 1, 0);
        add(0, 0, 1, 0, 5, 1, 0);
        add(1, 9, 1, 0, 4, 1, 0);
        add(0, 0, 1, 1, 4, 0, 0);
        add(0, 0, 1, 1, 4, 0, 0);
        add(0, 0, 0, 0, 4, 0, 0);
        // stop beats expiry at q=1
        add(1, 2, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0);

        #12;
        check("reset_state", 0, 0, 0);
        @(negedge clk);
        aresetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // full range: 255 enabled cycles to tc
        v = '0;
        v.lv = 1'b1; v.val = 8'd255; v.en = 1'b1; v.eq = 8'd255; v.eb = 1'b1;
        run_vec(v, "load_255");
        lif.load_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tc !== 1'b1 && n < 300);
        applied++;
        if (n != 255) begin
            miscompares++;
            $display("FAIL full_range_cycles: got %0d, want 255", n);
        end
`ifdef LIBSV_COUNTERS_BINARY_DOWN_COUNTER_AUTORELOAD_EN
        check("full_range_expiry", 255, 1, 1);
`else
        check("full_range_expiry", 0, 0, 1);
`endif
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // async reset mid-count at q=7
        v = '0;
        v.lv = 1'b1; v.val = 8'd9; v.en = 1'b1; v.eq = 8'd9; v.eb = 1'b1;
        run_vec(v, "rst_load9");
        v.lv = 1'b0; v.eq = 8'd8;
        run_vec(v, "rst_q8");
        v.eq = 8'd7;
        run_vec(v, "rst_q7");
        #2;
        aresetn = 1'b0;
        #1;
        check("async_reset", 0, 0, 0);
        @(negedge clk);
        en = 1'b0;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/binary_down_counter.md
# binary_down_counter

Loadable N-bit binary down counter that counts a programmed value to zero and flags terminal count. It complements the free-running up counter in `counters/`: the up counter measures elapsed cycles, while this block counts a requested interval down to expiry. A producer writes the interval over a valid/ready load port. Consumers use the one-cycle terminal-count pulse as a timeout or tick, optionally periodic.

## Interface
- `N`, default 8: counter width in bits; N >= 2.

- `clk`  in  1  clock, rising edge
- `aresetn`  in  1  reset, asynchronous, active-low
- `load_valid`  in  1  load request
- `load_ready`  out  1  load can be accepted this cycle
- `load_value`  in  N  interval to count, unsigned
- `en`  in  1  count enable; when low in RUN, `q` holds
- `stop`  in  1  abort counting and return to IDLE
- `q`  out  N  current count, registered
- `busy`  out  1  high while in RUN
- `tc`  out  1  terminal-count pulse, registered, one cycle

## Operation
- States: IDLE and RUN. `busy` = (state == RUN).
- A load is accepted when `load_valid && load_ready`.
- Reload register `rl`, N bits, internal.
- IDLE, load accepted with `load_value` != 0: `q <= load_value`, `rl <= load_value`, go to RUN.
- IDLE, load accepted with `load_value` == 0: `q <= 0`, `rl <= 0`, `tc <= 1` for one cycle, stay in IDLE.
- RUN, `en` high, `q` > 1: `q <= q - 1`.
- RUN, `en` high, `q` == 1: `q <= 0`, `tc <= 1`, go to IDLE.
  - With auto-reload enabled, see Configuration.
- RUN, `en` low: `q` and state hold; `tc` stays 0.
- `stop` high in RUN, highest priority: go to IDLE, `q` holds its current value, no `tc`. `stop` in IDLE has no effect.
- `stop` and `q` == 1 with `en` in the same cycle: stop wins, so `q` stays 1 and no `tc`.
- `tc` is 0 in every cycle not named above.
- Arithmetic is unsigned modulo 2^N. `q` never underflows, because RUN is never entered with `q` == 0.
- `load_value` = 2^N-1 is legal: expiry takes 2^N-1 enabled cycles.
- Reset, at any time including mid-count: `q` = 0, `rl` = 0, `tc` = 0, state = IDLE, `busy` = 0, `load_ready` = 1. Any count in progress is discarded.

## Timing
- `load_ready` is combinational from state only, with no path from `load_valid`.
- Load accepted at edge k: `q` = `load_value` and `busy` = 1 from cycle k+1.
- With `en` held high and load value L, `q` reaches 0 and `tc` = 1 in the cycle starting L edges after the load edge.
- `tc` asserts in the same cycle that `q` first shows 0 (or shows the reloaded value, in auto-reload mode).
- `busy` falls in the same cycle `tc` rises, except in auto-reload mode.
- A new load is accepted in the cycle `tc` is high, since the block is already in IDLE there.

## Configuration
- Macro: `LIBSV_COUNTERS_BINARY_DOWN_COUNTER_AUTORELOAD_EN`.
- Undefined:
  - `load_ready` = !`busy`.
  - Loads during RUN are not accepted; the producer holds `load_valid` until back in IDLE.
  - The block is one-shot, as described in Operation.
- Defined:
  - `load_ready` = 1 in every state.
  - RUN, `en` high, `q` == 1: `q <= rl`, `tc <= 1`, stay in RUN. The `tc` period is `rl` enabled cycles.
  - A load accepted during RUN updates only `rl`. `q` is undisturbed, and the new value takes effect at the next reload.
  - A load of 0 accepted during RUN writes `rl` = 0. At the next expiry `q` <= 0, `tc` pulses, and the block goes to IDLE.
  - If `stop` and a load occur together in RUN: `rl` is updated and the block goes to IDLE with `q` held.

## Test plan
- Reset, then load 5 with `en`=1 held → `q` runs 5,4,3,2,1,0; `tc`=1 only in the cycle `q`=0; `busy` is 1 for exactly 5 cycles.
- Load 3, drop `en` for 4 cycles while `q`=2 → `q` holds 2, no `tc`; on re-enable `tc` fires 2 cycles later.
- Load 0 → `tc` single pulse the next cycle, `busy` stays 0. Load 2^N-1 with N=8 → `tc` after 255 enabled cycles.
- Non-auto build: assert `load_valid` during RUN → `load_ready`=0, `q` unaffected. Assert `stop` at `q`=4 → IDLE, `q`=4, no `tc`.
- Auto-reload build: load 4 → `tc` every 4 cycles. A load of 2 mid-period takes effect after the next `tc`. A load of 0 → one final `tc`, then IDLE.
- Assert `aresetn` low asynchronously mid-count at `q`=7 → `q`=0, `tc`=0, `busy`=0, `load_ready`=1 immediately, without waiting for a clock edge.
